// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one binary bit per clock.
// Start/busy/done handshake with a registered result and an overflow flag for narrow DIGITS.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] BCD_out,
  output logic                ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0] bcd_wr_q, bcd_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_wr_q, ovf_wr_d;
  logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
  logic             ovf_q, ovf_d;

  logic [BCD_W-1:0] bcd_corr;
  logic [BCD_W-1:0] bcd_shift;
  logic             shift_out;

  // Digit-wise add-3 correction: any digit >= 5 would exceed 9 after doubling.
  function automatic logic [BCD_W-1:0] add3_correct(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bin_sr_q  <= '0;
      bcd_wr_q  <= '0;
      cnt_q     <= '0;
      ovf_wr_q  <= 1'b0;
      bcd_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      bcd_wr_q  <= bcd_wr_d;
      cnt_q     <= cnt_d;
      ovf_wr_q  <= ovf_wr_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    bcd_wr_d  = bcd_wr_q;
    cnt_d     = cnt_q;
    ovf_wr_d  = ovf_wr_q;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;

    bcd_corr  = add3_correct(bcd_wr_q);
    bcd_shift = {bcd_corr[BCD_W-2:0], bin_sr_q[WIDTH-1]};
    shift_out = bcd_corr[BCD_W-1];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SHIFT;
          bin_sr_d = bin_in;
          bcd_wr_d = '0;
          cnt_d    = '0;
          ovf_wr_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        bcd_wr_d = bcd_shift;
        bin_sr_d = bin_sr_q << 1;
        ovf_wr_d = ovf_wr_q | shift_out;
        cnt_d    = cnt_q + CNT_W'(1);
        // Final step: publish the shifted value directly, no trailing correction.
        if (cnt_q == CNT_LAST) begin
          bcd_out_d = bcd_shift;
          ovf_d     = ovf_wr_q | shift_out;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign BCD_out = bcd_out_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and sweep checks for bin2bcd_seq; a 3-digit and a 2-digit instance share stimulus.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy, done, ovf;
  logic [11:0] bcd;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .BCD_out(bcd), .ovf(ovf)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .BCD_out(bcd2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Launch one conversion and return at the negedge where done is seen (or timeout).
  task automatic convert(input logic [7:0] v, input int glitch_at,
                         output logic [11:0] res, output logic o,
                         output logic [7:0] res2, output logic o2,
                         output int busy_n, output int lat);
    busy_n = 0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
    lat    = 1;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
      start = (lat == glitch_at);
      bin_in = start ? 8'd7 : ~v;
    end
    start = 1'b0;
    res   = bcd;
    o     = ovf;
    res2  = bcd2;
    o2    = ovf2;
  endtask

  logic [11:0] res;
  logic [7:0]  res2;
  logic        o, o2;
  int          bn, lat, seen;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    convert(8'd0, 0, res, o, res2, o2, bn, lat);
    check("zero_lat", lat, 9);
    check("zero_bcd", res, 12'h000);
    check("zero_ovf", o, 0);

    convert(8'd255, 0, res, o, res2, o2, bn, lat);
    check("max_bcd", res, 12'h255);
    check("max_ovf", o, 0);
    check("max_busy_cycles", bn, 8);
    check("max_d2_ovf", o2, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("hold_bcd", bcd, 12'h255);

    // Back-to-back: start held in the DONE cycle.
    convert(8'd99, 0, res, o, res2, o2, bn, lat);
    check("b2b_first_bcd", res, 12'h099);
    check("d2_99_bcd", res2, 8'h99);
    check("d2_99_ovf", o2, 0);
    start  = 1'b1;
    bin_in = 8'd100;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'd0;
    lat    = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_gap", lat, 9);
    check("b2b_second_bcd", bcd, 12'h100);

    // start pulsed during SHIFT is ignored.
    convert(8'd42, 3, res, o, res2, o2, bn, lat);
    check("ign_lat", lat, 9);
    check("ign_bcd", res, 12'h042);

    // Reset in the 4th SHIFT cycle aborts the conversion.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd, 0);
    check("abort_ovf", ovf, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    convert(8'd13, 0, res, o, res2, o2, bn, lat);
    check("after_abort_bcd", res, 12'h013);

    for (int v = 0; v < 256; v++) begin
      convert(8'(v), 0, res, o, res2, o2, bn, lat);
      check($sformatf("sweep_lat_%0d", v), lat, 9);
      check($sformatf("sweep_bcd_%0d", v), res, ref_bcd(v));
      check($sformatf("sweep_ovf_%0d", v), o, 0);
      check($sformatf("sweep_d2_ovf_%0d", v), o2, (v > 99) ? 1 : 0);
      if (v <= 99) check($sformatf("sweep_d2_bcd_%0d", v), res2, ref_bcd(v) & 12'h0ff);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
